dma_bus_slave: RTL and testbench

- Memory-backed bus target: the responder end of the burst bus protocol driven by the DMA controller custom instruction.
- Decodes its address window and accepts single or burst writes into an internal word array.
- Returns single or burst reads with a configurable latency.
- Can insert periodic busy stalls, so DMA transfer, stall and error paths can be exercised against a real responder in simulation and on the virtual prototype.

---
 rtl/dma_bus_slave.sv | 199 +++++++++++++++++++
 tb/tb_dma_bus_slave.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_slave.sv
// Memory-backed bus responder for the DMA burst protocol.
// Decodes an address window, accepts single/burst writes with byte lanes,
// returns single/burst reads after a fixed latency and can insert periodic
// busy stalls on write beats. Every output is zero when not driving so it
// can be OR-ed onto the shared bus.
module dma_bus_slave #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned STALL_PERIOD = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        begin_transaction_in,
  input  logic [31:0] address_data_in,
  input  logic        read_n_write_in,
  input  logic [3:0]  byte_enables_in,
  input  logic [7:0]  burst_size_in,
  input  logic        data_valid_in,
  input  logic        end_transaction_in,
  input  logic        bus_error_in,
  output logic [31:0] address_data_out,
  output logic        data_valid_out,
  output logic        end_transaction_out,
  output logic        busy_out,
  output logic        bus_error_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 9;
  localparam int unsigned SCW   = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  typedef enum logic [2:0] {
    IDLE, READ_WAIT, READ_BURST, READ_END, WRITE, ERROR
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] ptr, ptr_n;
  logic [8:0]            beat, beat_n;
  logic [7:0]            burst, burst_n;
  logic [3:0]            be, be_n;
  logic [3:0]            wait_cnt, wait_n;
  logic [SCW-1:0]        stall_cnt, stall_n;
  logic [31:0]           data_n;
  logic                  valid_n, end_n, busy_n, err_n;

  logic                  we_c;
  logic                  sel_c;
  logic                  bad_c;
  logic [ADDR_WIDTH-1:0] index_c;
  logic [ADDR_WIDTH-1:0] rd_next_c;

  // State, transaction context and registered bus outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      ptr                 <= '0;
      beat                <= '0;
      burst               <= '0;
      be                  <= '0;
      wait_cnt            <= '0;
      stall_cnt           <= '0;
      address_data_out    <= '0;
      data_valid_out      <= 1'b0;
      end_transaction_out <= 1'b0;
      busy_out            <= 1'b0;
      bus_error_out       <= 1'b0;
    end else begin
      state               <= state_n;
      ptr                 <= ptr_n;
      beat                <= beat_n;
      burst               <= burst_n;
      be                  <= be_n;
      wait_cnt            <= wait_n;
      stall_cnt           <= stall_n;
      address_data_out    <= data_n;
      data_valid_out      <= valid_n;
      end_transaction_out <= end_n;
      busy_out            <= busy_n;
      bus_error_out       <= err_n;
    end
  end

  // Word array; contents survive reset. Byte lanes come from the begin cycle.
  always_ff @(posedge clock) begin
    if (we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[ptr][8*i +: 8] <= address_data_in[8*i +: 8];
      end
    end
  end

  // Decode, next-state and next-output logic.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    beat_n    = beat;
    burst_n   = burst;
    be_n      = be;
    wait_n    = wait_cnt;
    stall_n   = stall_cnt;
    data_n    = '0;
    valid_n   = 1'b0;
    end_n     = 1'b0;
    busy_n    = 1'b0;
    err_n     = 1'b0;
    we_c      = 1'b0;
    index_c   = address_data_in[ADDR_WIDTH+1:2];
    sel_c     = (address_data_in[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]);
    bad_c     = (address_data_in[1:0] != 2'b00) ||
                ((CW'(index_c) + CW'(burst_size_in)) > CW'(DEPTH - 1));
    rd_next_c = ptr + ADDR_WIDTH'(1);

    case (state)
      IDLE: begin
        // A bus error in the begin cycle suppresses the transaction.
        if (begin_transaction_in && !bus_error_in && sel_c) begin
          ptr_n   = index_c;
          beat_n  = '0;
          burst_n = burst_size_in;
          be_n    = byte_enables_in;
          stall_n = '0;
          if (bad_c) begin
            state_n = ERROR;
            err_n   = 1'b1;
            end_n   = 1'b1;
          end else if (read_n_write_in) begin
            if (READ_LATENCY <= 1) begin
              state_n = READ_BURST;
              valid_n = 1'b1;
              data_n  = mem[index_c];
            end else begin
              state_n = READ_WAIT;
              wait_n  = 4'(READ_LATENCY - 1);
            end
          end else begin
            state_n = WRITE;
          end
        end
      end
      READ_WAIT: begin
        if (wait_cnt == 4'd1) begin
          state_n = READ_BURST;
          valid_n = 1'b1;
          data_n  = mem[ptr];
        end else begin
          wait_n = wait_cnt - 4'd1;
        end
      end
      READ_BURST: begin
        // ptr/beat describe the beat currently on the bus.
        if (beat == 9'(burst)) begin
          state_n = READ_END;
          end_n   = 1'b1;
        end else begin
          beat_n  = beat + 9'd1;
          ptr_n   = rd_next_c;
          valid_n = 1'b1;
          data_n  = mem[rd_next_c];
        end
      end
      READ_END: state_n = IDLE;
      WRITE: begin
        if (data_valid_in && !busy_out) begin
          // Beats past the requested length are accepted but dropped.
          if (beat <= 9'(burst)) begin
            we_c   = 1'b1;
            beat_n = beat + 9'd1;
            ptr_n  = ptr + ADDR_WIDTH'(1);
          end
          if (STALL_PERIOD != 0) begin
            if (stall_cnt == SCW'(STALL_PERIOD - 1)) begin
              busy_n  = 1'b1;
              stall_n = '0;
            end else begin
              stall_n = stall_cnt + SCW'(1);
            end
          end
        end
      end
      ERROR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Master end or arbiter error aborts any active transaction.
    if ((state != IDLE) && (end_transaction_in || bus_error_in)) begin
      state_n = IDLE;
      data_n  = '0;
      valid_n = 1'b0;
      end_n   = 1'b0;
      busy_n  = 1'b0;
      err_n   = 1'b0;
      we_c    = 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_bus_slave.sv
// Directed plus randomized bench for dma_bus_slave with a word-level
// reference memory and a beat-count stall model.
module tb_dma_bus_slave;

  localparam logic [31:0] BASE = 32'h5000_0000;
  localparam int          AW   = 8;
  localparam int          DEP  = 256;
  localparam int          LAT  = 2;
  localparam int          STALL = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        begin_t = 1'b0;
  logic [31:0] adi = '0;
  logic        rnw = 1'b0;
  logic [3:0]  be_in = '0;
  logic [7:0]  burst_in = '0;
  logic        dv = 1'b0;
  logic        end_in = 1'b0;
  logic        err_in = 1'b0;
  logic [31:0] ado;
  logic        dvo, eto, busy, beo;

  logic [31:0] ref_mem [DEP];
  logic [31:0] wbuf [300];
  int          checks = 0;
  int          errors = 0;

  dma_bus_slave #(
    .BASE_ADDRESS(BASE), .ADDR_WIDTH(AW), .READ_LATENCY(LAT), .STALL_PERIOD(STALL)
  ) dut (
    .clock(clock), .reset(reset),
    .begin_transaction_in(begin_t), .address_data_in(adi), .read_n_write_in(rnw),
    .byte_enables_in(be_in), .burst_size_in(burst_in), .data_valid_in(dv),
    .end_transaction_in(end_in), .bus_error_in(err_in),
    .address_data_out(ado), .data_valid_out(dvo), .end_transaction_out(eto),
    .busy_out(busy), .bus_error_out(beo)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 64'({ado, dvo, eto, busy, beo}), 64'd0);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] lanes);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (lanes[l]) r[8*l +: 8] = nw[8*l +: 8];
    return r;
  endfunction

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr - BASE) >> 2);
  endfunction

  // Write nbeats words from wbuf; the master holds a beat while busy.
  task automatic do_write(input logic [31:0] addr, input int burst, input logic [3:0] lanes,
                          input int nbeats, output int busy_seen);
    int idx, i, acc, guard;
    logic pending;
    idx = idx_of(addr);
    i = 0; acc = 0; guard = 0; pending = 1'b0; busy_seen = 0;
    begin_t = 1'b1; adi = addr; rnw = 1'b0; be_in = lanes; burst_in = 8'(burst);
    step();
    begin_t = 1'b0; be_in = '0; burst_in = '0;
    while (i < nbeats && guard < nbeats * 2 + 8) begin
      dv = 1'b1; adi = wbuf[i];
      chk("wr_busy", 64'(busy), 64'(pending));
      chk("wr_no_end", 64'(eto), 64'd0);
      if (busy) busy_seen++;
      if (!pending) begin
        if (i <= burst) ref_mem[idx + i] = merge(ref_mem[idx + i], wbuf[i], lanes);
        i++; acc++;
        pending = ((acc % STALL) == 0);
      end else begin
        pending = 1'b0;
      end
      step();
      guard++;
    end
    chk("wr_beats", 64'(i), 64'(nbeats));
    dv = 1'b0; adi = '0; end_in = 1'b1;
    chk("wr_busy_last", 64'(busy), 64'(pending));
    if (busy) busy_seen++;
    step();
    end_in = 1'b0;
    chk_idle("wr_after");
  endtask

  // Read burst+1 words; optionally abort or reset during beat number abort_at/reset_at.
  task automatic do_read(input logic [31:0] addr, input int burst, input int abort_at,
                         input int reset_at);
    int idx;
    idx = idx_of(addr);
    begin_t = 1'b1; adi = addr; rnw = 1'b1; burst_in = 8'(burst);
    step();
    begin_t = 1'b0; adi = '0; rnw = 1'b0; burst_in = '0;
    for (int k = 1; k < LAT; k++) begin
      chk_idle("rd_latency");
      step();
    end
    for (int b = 0; b <= burst; b++) begin
      chk("rd_valid", 64'(dvo), 64'd1);
      chk("rd_data", 64'(ado), 64'(ref_mem[idx + b]));
      chk("rd_end_early", 64'(eto), 64'd0);
      if (b == abort_at) begin
        end_in = 1'b1;
        step();
        end_in = 1'b0;
        chk_idle("rd_abort");
        return;
      end
      if (b == reset_at) begin
        #2 reset = 1'b1;
        #1 chk_idle("rst_async");
        step();
        reset = 1'b0;
        step();
        chk_idle("rst_after");
        return;
      end
      step();
    end
    chk("rd_end", 64'(eto), 64'd1);
    chk("rd_end_valid", 64'(dvo), 64'd0);
    chk("rd_end_data", 64'(ado), 64'd0);
    step();
    chk_idle("rd_after");
  endtask

  // Begin that must be answered by a one-cycle error termination.
  task automatic do_error(input logic [31:0] addr, input int burst, input logic rd);
    begin_t = 1'b1; adi = addr; rnw = rd; be_in = 4'hF; burst_in = 8'(burst);
    step();
    begin_t = 1'b0; adi = '0; rnw = 1'b0; be_in = '0; burst_in = '0;
    chk("err_flag", 64'(beo), 64'd1);
    chk("err_end", 64'(eto), 64'd1);
    chk("err_quiet", 64'({ado, dvo, busy}), 64'd0);
    step();
    chk_idle("err_after");
  endtask

  initial begin
    int bs, idx, burst, extra;
    logic [31:0] a;

    // Reset state.
    step();
    step();
    chk_idle("reset_state");
    reset = 1'b0;
    step();
    chk_idle("post_reset");

    // Fill the whole window in one maximal burst so every word is known.
    for (int i = 0; i < DEP; i++) wbuf[i] = $urandom;
    do_write(BASE, 255, 4'hF, 256, bs);
    chk("fill_stalls", 64'(bs), 64'(DEP / STALL));

    // 1: single write then read.
    wbuf[0] = 32'hDEAD_BEEF;
    do_write(32'h5000_0010, 0, 4'hF, 1, bs);
    do_read(32'h5000_0010, 0, -1, -1);

    // 2: burst write with stalls, then read back.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'(i);
    do_write(32'h5000_0000, 7, 4'hF, 8, bs);
    chk("burst_stalls", 64'(bs), 64'd2);
    do_read(32'h5000_0000, 7, -1, -1);

    // 3: byte enables.
    wbuf[0] = 32'h1122_3344;
    do_write(32'h5000_0020, 0, 4'hF, 1, bs);
    wbuf[0] = 32'hAABB_CCDD;
    do_write(32'h5000_0020, 0, 4'b0101, 1, bs);
    do_read(32'h5000_0020, 0, -1, -1);

    // Extra beats beyond the burst are dropped.
    for (int i = 0; i < 5; i++) wbuf[i] = $urandom;
    do_write(32'h5000_0040, 1, 4'hF, 5, bs);
    do_read(32'h5000_0040, 3, -1, -1);

    // 4: window overrun, unaligned, boundaries, unselected.
    do_error(32'h5000_03F8, 3, 1'b0);
    do_error(32'h5000_03F8, 2, 1'b1);
    do_error(32'h5000_0012, 0, 1'b1);
    do_read(32'h5000_03F8, 1, -1, -1);
    do_read(32'h5000_03FC, 0, -1, -1);
    begin_t = 1'b1; adi = 32'h6000_0000; rnw = 1'b1; burst_in = 8'd3;
    step();
    begin_t = 1'b0; adi = '0; rnw = 1'b0; burst_in = '0;
    for (int k = 0; k < 4; k++) begin
      chk_idle("unselected");
      step();
    end

    // Begin together with bus error: nothing starts, offered data is not written.
    begin_t = 1'b1; err_in = 1'b1; adi = 32'h5000_0080; rnw = 1'b0; be_in = 4'hF;
    step();
    begin_t = 1'b0; err_in = 1'b0; be_in = '0;
    chk_idle("begin_vs_error");
    dv = 1'b1; adi = 32'h0BAD_F00D;
    step();
    dv = 1'b0; adi = '0;
    chk_idle("begin_vs_error2");
    do_read(32'h5000_0080, 0, -1, -1);

    // 5: read abort after 3 beats, new begin two cycles after the abort.
    do_read(32'h5000_0100, 15, 3, -1);
    step();
    chk_idle("abort_gap");
    do_read(32'h5000_0100, 2, -1, -1);

    // 6: reset during beat 2 of a read burst, then read previously written data.
    do_read(32'h5000_0000, 7, -1, 2);
    do_read(32'h5000_0000, 7, -1, -1);

    // Randomized write/read traffic against the reference memory.
    for (int n = 0; n < 20; n++) begin
      idx = int'($urandom_range(0, DEP - 1));
      burst = int'($urandom_range(0, 15));
      if (idx + burst > DEP - 1) burst = DEP - 1 - idx;
      extra = int'($urandom_range(0, 2));
      for (int i = 0; i < burst + 1 + extra; i++) wbuf[i] = $urandom;
      a = BASE + 32'(idx * 4);
      do_write(a, burst, 4'($urandom_range(0, 15)), burst + 1 + extra, bs);
      idx = int'($urandom_range(0, DEP - 1));
      burst = int'($urandom_range(0, 15));
      if (idx + burst > DEP - 1) burst = DEP - 1 - idx;
      do_read(BASE + 32'(idx * 4), burst, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
